// File: rtl/lp_four_to_six.sv
// 4-to-6 sample gearbox: repacks a 4-sample/clk stream into 6-sample words
// qualified by a 0,1,1 clock-enable pattern (12 samples per 3 clocks).
module lp_four_to_six #(
  parameter int NBITS = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sync_i,
  input  logic [4*NBITS-1:0] dat_i,
  output logic [6*NBITS-1:0] dat_o,
  output logic               ce_o,
  output logic               align_err_o
);

  typedef enum logic [1:0] {PH0 = 2'd0, PH1 = 2'd1, PH2 = 2'd2} phase_t;

  phase_t             phase, ph, phase_nxt;
  logic [4*NBITS-1:0] hold, hold_nxt;
  logic [6*NBITS-1:0] dat_nxt;
  logic               ce_nxt, err_nxt;

  always_comb begin
    // sync restarts the group on the current word
    ph        = sync_i ? PH0 : phase;
    phase_nxt = PH0;
    hold_nxt  = hold;
    dat_nxt   = dat_o;
    ce_nxt    = 1'b0;
    err_nxt   = align_err_o | (sync_i && (phase != PH0));
    case (ph)
      PH0: begin
        phase_nxt = PH1;
        hold_nxt  = dat_i;
      end
      PH1: begin
        phase_nxt = PH2;
        dat_nxt   = {dat_i[0 +: 2*NBITS], hold};
        ce_nxt    = 1'b1;
        hold_nxt[0 +: 2*NBITS] = dat_i[2*NBITS +: 2*NBITS];
      end
      PH2: begin
        phase_nxt = PH0;
        dat_nxt   = {dat_i, hold[0 +: 2*NBITS]};
        ce_nxt    = 1'b1;
      end
      default: phase_nxt = PH0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase       <= PH0;
      hold        <= '0;
      dat_o       <= '0;
      ce_o        <= 1'b0;
      align_err_o <= 1'b0;
    end else begin
      phase       <= phase_nxt;
      hold        <= hold_nxt;
      dat_o       <= dat_nxt;
      ce_o        <= ce_nxt;
      align_err_o <= err_nxt;
    end
  end

endmodule

// File: tb/tb_lp_four_to_six.sv
// Randomized and directed bench for lp_four_to_six against a sample-group model.
module tb_lp_four_to_six;
  localparam int NB = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1, sync = 1'b0;
  logic [4*NB-1:0] dat = '0;
  logic [6*NB-1:0] dat_o;
  logic            ce, err;

  int total = 0, bad = 0;

  // reference model: one 12-sample group, sliced into two 6-sample words
  int              m_phase = 0;
  logic [NB-1:0]   m_grp [12];
  logic [6*NB-1:0] m_dat = '0;
  logic            m_ce = 1'b0, m_err = 1'b0;

  lp_four_to_six #(.NBITS(NB)) dut (
    .clk_i(clk), .rst_i(rst), .sync_i(sync), .dat_i(dat),
    .dat_o(dat_o), .ce_o(ce), .align_err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [4*NB-1:0] ramp(input int n);
    logic [4*NB-1:0] w;
    for (int k = 0; k < 4; k++) w[k*NB +: NB] = NB'(4*n + k);
    return w;
  endfunction

  function automatic logic [6*NB-1:0] pack6(input int base);
    logic [6*NB-1:0] w;
    for (int k = 0; k < 6; k++) w[k*NB +: NB] = NB'(base + k);
    return w;
  endfunction

  task automatic model(input logic r, input logic s, input logic [4*NB-1:0] d);
    int p;
    if (r) begin
      m_phase = 0; m_dat = '0; m_ce = 1'b0; m_err = 1'b0;
      for (int k = 0; k < 12; k++) m_grp[k] = '0;
    end else begin
      p = s ? 0 : m_phase;
      if (s && m_phase != 0) m_err = 1'b1;
      for (int k = 0; k < 4; k++) m_grp[p*4 + k] = d[k*NB +: NB];
      m_ce = (p != 0);
      if (p == 1) for (int k = 0; k < 6; k++) m_dat[k*NB +: NB] = m_grp[k];
      if (p == 2) for (int k = 0; k < 6; k++) m_dat[k*NB +: NB] = m_grp[6 + k];
      m_phase = (p + 1) % 3;
    end
  endtask

  // drive one word, clock it in, advance the model, sample 1ns after the edge
  task automatic step(input logic r, input logic s, input logic [4*NB-1:0] d);
    rst = r; sync = s; dat = d;
    @(posedge clk);
    model(r, s, d);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom});
      total++;
      if (dat_o !== '0 || ce !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL reset cyc%0d got dat=%h ce=%b err=%b want 0/0/0", i, dat_o, ce, err);
      end
    end
  endtask

  task automatic test_ramp_start();
    logic [6*NB-1:0] want;
    step(1'b1, 1'b0, '0);
    for (int n = 0; n < 6; n++) begin
      step(1'b0, 1'b0, ramp(n));
      total++;
      if (ce !== (n % 3 != 0)) begin
        bad++;
        $display("FAIL ramp_ce n=%0d got %b want %b", n, ce, (n % 3 != 0));
      end
      if (n % 3 != 0) begin
        want = pack6(12*(n/3) + ((n % 3 == 2) ? 6 : 0));
        total++;
        if (dat_o !== want) begin
          bad++;
          $display("FAIL ramp_dat n=%0d got %h want %h", n, dat_o, want);
        end
      end
    end
  endtask

  task automatic test_long_ramp();
    int next_s = 0, ce_cnt = 0;
    logic ok;
    step(1'b1, 1'b0, '0);
    for (int n = 0; n < 3000; n++) begin
      step(1'b0, 1'b0, ramp(n));
      total++;
      if (dat_o !== m_dat || ce !== m_ce || err !== m_err) begin
        bad++;
        $display("FAIL long_model n=%0d got %h/%b/%b want %h/%b/%b", n, dat_o, ce, err, m_dat, m_ce, m_err);
      end
      if (ce === 1'b1) begin
        ok = 1'b1;
        for (int k = 0; k < 6; k++) if (dat_o[k*NB +: NB] !== NB'(next_s + k)) ok = 1'b0;
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL long_stream n=%0d got %h want %h", n, dat_o, pack6(next_s));
        end
        next_s += 6;
        ce_cnt++;
      end
    end
    total++;
    if (ce_cnt != 2000) begin
      bad++;
      $display("FAIL long_ce_count got %0d want 2000", ce_cnt);
    end
  endtask

  task automatic test_sync_ph0();
    step(1'b1, 1'b0, '0);
    for (int n = 0; n < 9; n++) begin
      step(1'b0, (n == 3), ramp(n));
      total++;
      if (ce !== (n % 3 != 0) || err !== 1'b0 ||
          (n % 3 != 0 && dat_o !== pack6(12*(n/3) + ((n % 3 == 2) ? 6 : 0)))) begin
        bad++;
        $display("FAIL sync_ph0 n=%0d got %h/%b/%b want %h/%b/0", n, dat_o, ce, err,
                 pack6(12*(n/3) + ((n % 3 == 2) ? 6 : 0)), (n % 3 != 0));
      end
    end
  endtask

  task automatic test_sync_misaligned();
    step(1'b1, 1'b0, '0);
    for (int n = 0; n < 12; n++) begin
      step(1'b0, (n == 5), ramp(n));
      total++;
      if (dat_o !== m_dat || ce !== m_ce || err !== m_err) begin
        bad++;
        $display("FAIL sync_model n=%0d got %h/%b/%b want %h/%b/%b", n, dat_o, ce, err, m_dat, m_ce, m_err);
      end
      if (n == 5) begin
        total++;
        if (ce !== 1'b0 || err !== 1'b1) begin
          bad++;
          $display("FAIL sync_abandon got ce=%b err=%b want ce=0 err=1", ce, err);
        end
      end
      if (n == 6 || n == 7) begin
        total++;
        if (ce !== 1'b1 || dat_o !== pack6(n == 6 ? 20 : 26)) begin
          bad++;
          $display("FAIL sync_regroup n=%0d got %h ce=%b want %h ce=1", n, dat_o, ce, pack6(n == 6 ? 20 : 26));
        end
      end
      if (n > 5) begin
        total++;
        if (err !== 1'b1) begin
          bad++;
          $display("FAIL sync_sticky n=%0d got err=%b want 1", n, err);
        end
      end
    end
  endtask

  task automatic test_reset_mid_group();
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, ramp(0));
    step(1'b0, 1'b0, ramp(1));
    step(1'b0, 1'b1, ramp(2));   // misaligned sync sets the sticky error
    step(1'b1, 1'b0, ramp(3));   // reset lands in phase 1
    total++;
    if (ce !== 1'b0 || dat_o !== '0 || err !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got %h/%b/%b want 0/0/0", dat_o, ce, err);
    end
    for (int n = 100; n < 103; n++) begin
      step(1'b0, 1'b0, ramp(n));
      total++;
      if (ce !== (n != 100) || (n != 100 && dat_o !== pack6(n == 101 ? 400 : 406))) begin
        bad++;
        $display("FAIL rst_regroup n=%0d got %h ce=%b want %h ce=%b", n, dat_o, ce,
                 pack6(n == 101 ? 400 : 406), (n != 100));
      end
    end
  endtask

  task automatic test_random();
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 14) == 0), {$urandom, $urandom});
      total++;
      if (dat_o !== m_dat || ce !== m_ce || err !== m_err) begin
        bad++;
        $display("FAIL random i=%0d got %h/%b/%b want %h/%b/%b", i, dat_o, ce, err, m_dat, m_ce, m_err);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 12; k++) m_grp[k] = '0;
    test_reset();
    test_ramp_start();
    test_long_ramp();
    test_sync_ph0();
    test_sync_misaligned();
    test_reset_mid_group();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
